// File: rtl/ras_checkpoint_queue_if.sv
// Checkpoint queue bus: push/retire/recover requests from fetch and commit,
// restore data back to the return-address stack.
interface ras_checkpoint_queue_if #(
    parameter int ENTRY_NUM     = 16,
    parameter int RAS_ENTRY_NUM = 16,
    parameter int PC_WIDTH      = 32
);
    localparam int IW = $clog2(RAS_ENTRY_NUM);
    localparam int TW = $clog2(ENTRY_NUM);

    // Handshake: a push is taken on a rising clk edge only when pushValid
    // and pushReady are both 1 in that cycle. pushReady never depends on
    // pushValid. retireValid and recoverValid have no ready; the queue
    // decides legality itself and silently drops illegal requests.
    logic                pushValid;
    logic [IW-1:0]       pushRasPtr;
    logic [PC_WIDTH-1:0] pushRasEntry;
    logic                pushReady;
    logic [TW-1:0]       pushTag;
    logic                retireValid;
    logic                recoverValid;
    logic [TW-1:0]       recoverTag;
    logic                restoreValid;
    logic [IW-1:0]       restoreRasPtr;
    logic [PC_WIDTH-1:0] restoreRasEntry;
    logic [TW:0]         count;

    modport slave (
        input  pushValid, pushRasPtr, pushRasEntry, retireValid,
               recoverValid, recoverTag,
        output pushReady, pushTag, restoreValid, restoreRasPtr,
               restoreRasEntry, count
    );

    modport master (
        output pushValid, pushRasPtr, pushRasEntry, retireValid,
               recoverValid, recoverTag,
        input  pushReady, pushTag, restoreValid, restoreRasPtr,
               restoreRasEntry, count
    );
endinterface

// File: rtl/ras_checkpoint_queue.sv
// Circular queue of return-address-stack checkpoints; a recover rolls the
// queue back to a slot and replays that slot's pointer/entry to the stack.
module ras_checkpoint_queue #(
    parameter int ENTRY_NUM     = 16,
    parameter int RAS_ENTRY_NUM = 16,
    parameter int PC_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    ras_checkpoint_queue_if.slave   bus
);
    localparam int IW = $clog2(RAS_ENTRY_NUM);
    localparam int TW = $clog2(ENTRY_NUM);
    localparam logic [TW:0] FULL = (TW+1)'(ENTRY_NUM);

    logic [TW-1:0]       head_q, head_d;
    logic [TW-1:0]       tail_q, tail_d;
    logic [TW:0]         count_q, count_d;

    logic [IW-1:0]       ptr_mem   [ENTRY_NUM];
    logic [PC_WIDTH-1:0] entry_mem [ENTRY_NUM];

    logic                restore_valid_q;
    logic [IW-1:0]       restore_ptr_q;
    logic [PC_WIDTH-1:0] restore_entry_q;

    logic [TW-1:0]       off;
    logic                recover_legal;
    logic                push_ready;
    logic                push_fire;
    logic                retire_fire;

    // Slot distance from the oldest entry; TW-bit subtraction wraps mod ENTRY_NUM.
    assign off           = bus.recoverTag - head_q;
    assign recover_legal = bus.recoverValid && ({1'b0, off} < count_q);

    assign push_ready  = (count_q != FULL) && !bus.recoverValid;
    assign push_fire   = bus.pushValid && push_ready;
    // Recovering to the head slot empties the queue, so a retire then has nothing to free.
    assign retire_fire = bus.retireValid && (count_q != '0) &&
                         !(recover_legal && (off == '0));

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (recover_legal) begin
            tail_d  = bus.recoverTag;
            head_d  = head_q + TW'(retire_fire);
            count_d = {1'b0, off} - (TW+1)'(retire_fire);
        end else begin
            head_d  = head_q + TW'(retire_fire);
            tail_d  = tail_q + TW'(push_fire);
            count_d = count_q + (TW+1)'(push_fire) - (TW+1)'(retire_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            ptr_mem[tail_q]   <= bus.pushRasPtr;
            entry_mem[tail_q] <= bus.pushRasEntry;
        end
    end

    // Pushes are blocked in recover cycles, so the read never races a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            restore_valid_q <= 1'b0;
            restore_ptr_q   <= '0;
            restore_entry_q <= '0;
        end else begin
            restore_valid_q <= recover_legal;
            if (recover_legal) begin
                restore_ptr_q   <= ptr_mem[bus.recoverTag];
                restore_entry_q <= entry_mem[bus.recoverTag];
            end
        end
    end

    assign bus.pushReady       = push_ready;
    assign bus.pushTag         = tail_q;
    assign bus.count           = count_q;
    assign bus.restoreValid    = restore_valid_q;
    assign bus.restoreRasPtr   = restore_ptr_q;
    assign bus.restoreRasEntry = restore_entry_q;
endmodule

// File: tb/tb_ras_checkpoint_queue.sv
// Bench for ras_checkpoint_queue (4 slots): directed scenarios plus random
// traffic against a queue-based reference model.
module tb_ras_checkpoint_queue;
    localparam int W = 2 + 4 + 32;  // {tag, ptr, entry}

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ras_checkpoint_queue_if #(.ENTRY_NUM(4), .RAS_ENTRY_NUM(16), .PC_WIDTH(32)) bus ();

    ras_checkpoint_queue #(.ENTRY_NUM(4), .RAS_ENTRY_NUM(16), .PC_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: live checkpoints oldest-first, next tag, restore outputs.
    logic [W-1:0]  exp_q[$];
    int            m_tail;
    logic          m_rv;
    logic [3:0]    m_rptr;
    logic [31:0]   m_rent;

    task automatic model_reset();
        exp_q.delete();
        m_tail = 0;
        m_rv   = 1'b0;
        m_rptr = '0;
        m_rent = '0;
    endtask

    task automatic model_step(input bit pv, input logic [3:0] ptr, input logic [31:0] ent,
                              input bit rt, input bit rc, input logic [1:0] tag);
        int  idx = -1;
        bit  do_retire;
        m_rv = 1'b0;
        if (rc)
            for (int i = 0; i < exp_q.size(); i++)
                if (exp_q[i][37:36] == tag) idx = i;
        if (idx >= 0) begin
            m_rv   = 1'b1;
            m_rptr = exp_q[idx][35:32];
            m_rent = exp_q[idx][31:0];
            while (exp_q.size() > idx) void'(exp_q.pop_back());
            m_tail = int'(tag);
            if (rt && idx > 0) void'(exp_q.pop_front());
        end else begin
            do_retire = rt && (exp_q.size() > 0);
            if (pv && !rc && exp_q.size() < 4) begin
                exp_q.push_back({2'(m_tail), ptr, ent});
                m_tail = (m_tail + 1) % 4;
            end
            if (do_retire) void'(exp_q.pop_front());
        end
    endtask

    task automatic apply(input bit pv, input logic [3:0] ptr, input logic [31:0] ent,
                         input bit rt, input bit rc, input logic [1:0] tag);
        bus.pushValid    = pv;
        bus.pushRasPtr   = ptr;
        bus.pushRasEntry = ent;
        bus.retireValid  = rt;
        bus.recoverValid = rc;
        bus.recoverTag   = tag;
        model_step(pv, ptr, ent, rt, rc, tag);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.pushValid    = 1'b0;
        bus.retireValid  = 1'b0;
        bus.recoverValid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.pushValid    = 1'b0;
        bus.retireValid  = 1'b0;
        bus.recoverValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (bus.count !== 3'd0) begin $display("FAIL reset_count got %0d want 0", bus.count); n_err++; end
        n_vec++; if (bus.pushReady !== 1'b1) begin $display("FAIL reset_ready got %0b want 1", bus.pushReady); n_err++; end
        n_vec++; if (bus.pushTag !== 2'd0) begin $display("FAIL reset_tag got %0d want 0", bus.pushTag); n_err++; end
        n_vec++; if (bus.restoreValid !== 1'b0) begin $display("FAIL reset_rv got %0b want 0", bus.restoreValid); n_err++; end
        n_vec++; if (bus.restoreRasPtr !== 4'd0 || bus.restoreRasEntry !== 32'd0) begin
            $display("FAIL reset_restore got %0d/%h want 0/0", bus.restoreRasPtr, bus.restoreRasEntry); n_err++; end
    endtask

    task automatic test_push_sequence();
        logic [3:0]  ptrs [3] = '{4'd3, 4'd4, 4'd5};
        logic [31:0] ents [3] = '{32'h100, 32'h200, 32'h300};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, ptrs[i], ents[i], 1'b0, 1'b0, 2'd0);
            n_vec++; if (bus.pushTag !== 2'(i) || bus.pushReady !== 1'b1) begin
                $display("FAIL push_tag%0d got %0d/%0b want %0d/1", i, bus.pushTag, bus.pushReady, i); n_err++; end
            tick();
        end
        n_vec++; if (bus.count !== 3'd3) begin $display("FAIL push_count got %0d want 3", bus.count); n_err++; end
    endtask

    task automatic test_recover();
        apply(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd1);
        tick();
        n_vec++; if (bus.restoreValid !== 1'b1 || bus.restoreRasPtr !== 4'd4 || bus.restoreRasEntry !== 32'h200) begin
            $display("FAIL recover_data got %0b/%0d/%h want 1/4/200", bus.restoreValid, bus.restoreRasPtr, bus.restoreRasEntry); n_err++; end
        n_vec++; if (bus.count !== 3'd1) begin $display("FAIL recover_count got %0d want 1", bus.count); n_err++; end
        tick();
        n_vec++; if (bus.restoreValid !== 1'b0 || bus.restoreRasPtr !== 4'd4 || bus.restoreRasEntry !== 32'h200) begin
            $display("FAIL recover_hold got %0b/%0d/%h want 0/4/200", bus.restoreValid, bus.restoreRasPtr, bus.restoreRasEntry); n_err++; end
        apply(1'b1, 4'd6, 32'h400, 1'b0, 1'b0, 2'd0);
        n_vec++; if (bus.pushTag !== 2'd1) begin $display("FAIL recover_next_tag got %0d want 1", bus.pushTag); n_err++; end
        tick();
    endtask

    task automatic test_illegal_recover();
        do_reset();
        for (int i = 0; i < 2; i++) begin apply(1'b1, 4'(i), 32'(i), 1'b0, 1'b0, 2'd0); tick(); end
        apply(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd3);
        tick();
        n_vec++; if (bus.restoreValid !== 1'b0 || bus.count !== 3'd2) begin
            $display("FAIL illegal_recover got rv=%0b cnt=%0d want rv=0 cnt=2", bus.restoreValid, bus.count); n_err++; end
        for (int i = 0; i < 3; i++) begin apply(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 2'd0); tick(); end
        n_vec++; if (bus.count !== 3'd0) begin $display("FAIL empty_retire got %0d want 0", bus.count); n_err++; end
        n_vec++; if (bus.pushTag !== 2'd2) begin $display("FAIL empty_retire_tag got %0d want 2", bus.pushTag); n_err++; end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) begin apply(1'b1, 4'(i + 8), 32'(i + 'h50), 1'b0, 1'b0, 2'd0); tick(); end
        n_vec++; if (bus.count !== 3'd4 || bus.pushReady !== 1'b0) begin
            $display("FAIL full got cnt=%0d rdy=%0b want 4/0", bus.count, bus.pushReady); n_err++; end
        apply(1'b1, 4'd1, 32'hdead, 1'b0, 1'b0, 2'd0);
        tick();
        n_vec++; if (bus.count !== 3'd4) begin $display("FAIL full_push_drop got %0d want 4", bus.count); n_err++; end
        apply(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 2'd0);
        tick();
        apply(1'b1, 4'd2, 32'hbeef, 1'b0, 1'b0, 2'd0);
        n_vec++; if (bus.pushTag !== 2'd0 || bus.pushReady !== 1'b1) begin
            $display("FAIL wrap_tag got %0d/%0b want 0/1", bus.pushTag, bus.pushReady); n_err++; end
        tick();
        n_vec++; if (bus.count !== 3'd4) begin $display("FAIL wrap_count got %0d want 4", bus.count); n_err++; end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 3; i++) begin apply(1'b1, 4'(i + 1), 32'(i + 'h70), 1'b0, 1'b0, 2'd0); tick(); end
        apply(1'b1, 4'd15, 32'hffff, 1'b1, 1'b1, 2'd0);
        n_vec++; if (bus.pushReady !== 1'b0) begin $display("FAIL sim_ready got %0b want 0", bus.pushReady); n_err++; end
        tick();
        n_vec++; if (bus.restoreValid !== 1'b1 || bus.restoreRasPtr !== 4'd1 || bus.restoreRasEntry !== 32'h70) begin
            $display("FAIL sim_restore got %0b/%0d/%h want 1/1/70", bus.restoreValid, bus.restoreRasPtr, bus.restoreRasEntry); n_err++; end
        n_vec++; if (bus.count !== 3'd0 || bus.pushTag !== 2'd0) begin
            $display("FAIL sim_head got cnt=%0d tag=%0d want 0/0", bus.count, bus.pushTag); n_err++; end
        do_reset();
        for (int i = 0; i < 3; i++) begin apply(1'b1, 4'(i + 1), 32'(i + 'h70), 1'b0, 1'b0, 2'd0); tick(); end
        apply(1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 2'd2);
        tick();
        n_vec++; if (bus.restoreRasPtr !== 4'd3 || bus.restoreRasEntry !== 32'h72 || bus.count !== 3'd1) begin
            $display("FAIL sim_retire got %0d/%h cnt=%0d want 3/72 cnt=1", bus.restoreRasPtr, bus.restoreRasEntry, bus.count); n_err++; end
        n_vec++; if (bus.pushTag !== 2'd2) begin $display("FAIL sim_retire_tag got %0d want 2", bus.pushTag); n_err++; end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin apply(1'b1, 4'(i + 4), 32'(i + 'h90), 1'b0, 1'b0, 2'd0); tick(); end
        apply(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 2'd3);
        tick();
        n_vec++; if (bus.count !== 3'd3 || bus.restoreValid !== 1'b1) begin
            $display("FAIL pre_reset got cnt=%0d rv=%0b want 3/1", bus.count, bus.restoreValid); n_err++; end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (bus.count !== 3'd0 || bus.restoreValid !== 1'b0 || bus.pushReady !== 1'b1 || bus.pushTag !== 2'd0) begin
            $display("FAIL async_reset got cnt=%0d rv=%0b rdy=%0b tag=%0d want 0/0/1/0",
                     bus.count, bus.restoreValid, bus.pushReady, bus.pushTag); n_err++; end
        n_vec++; if (bus.restoreRasPtr !== 4'd0 || bus.restoreRasEntry !== 32'd0) begin
            $display("FAIL async_reset_data got %0d/%h want 0/0", bus.restoreRasPtr, bus.restoreRasEntry); n_err++; end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        apply(1'b1, 4'd9, 32'h1234, 1'b0, 1'b0, 2'd0);
        n_vec++; if (bus.pushTag !== 2'd0) begin $display("FAIL post_reset_tag got %0d want 0", bus.pushTag); n_err++; end
        tick();
        n_vec++; if (bus.count !== 3'd1) begin $display("FAIL post_reset_count got %0d want 1", bus.count); n_err++; end
    endtask

    task automatic test_random();
        bit          pv, rt, rc;
        logic [1:0]  tag;
        logic [3:0]  ptr;
        logic [31:0] ent;
        bit          e_ready;
        int          e_tag, e_count;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pv  = ($urandom_range(0, 1) == 1);
            rt  = ($urandom_range(0, 3) == 0);
            rc  = ($urandom_range(0, 7) == 0);
            tag = 2'($urandom_range(0, 3));
            ptr = 4'($urandom_range(0, 15));
            ent = $urandom;
            e_ready = (exp_q.size() < 4) && !rc;
            e_tag   = m_tail;
            e_count = exp_q.size();
            apply(pv, ptr, ent, rt, rc, tag);
            n_vec++; if (bus.pushReady !== e_ready || bus.pushTag !== 2'(e_tag) || bus.count !== 3'(e_count)) begin
                $display("FAIL rnd_pre[%0d] got rdy=%0b tag=%0d cnt=%0d want %0b/%0d/%0d",
                         n, bus.pushReady, bus.pushTag, bus.count, e_ready, e_tag, e_count); n_err++; end
            tick();
            n_vec++; if (bus.restoreValid !== m_rv || bus.restoreRasPtr !== m_rptr || bus.restoreRasEntry !== m_rent) begin
                $display("FAIL rnd_restore[%0d] got %0b/%0d/%h want %0b/%0d/%h", n, bus.restoreValid,
                         bus.restoreRasPtr, bus.restoreRasEntry, m_rv, m_rptr, m_rent); n_err++; end
        end
    endtask

    initial begin
        bus.pushValid    = 1'b0;
        bus.pushRasPtr   = '0;
        bus.pushRasEntry = '0;
        bus.retireValid  = 1'b0;
        bus.recoverValid = 1'b0;
        bus.recoverTag   = '0;
        model_reset();
        #12;
        test_reset();
        test_push_sequence();
        test_recover();
        test_illegal_recover();
        test_full_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
